bkm_delta_stats_checker: RTL and testbench
==========================================

# bkm_delta_stats_checker

Parametrised, multi-channel result checker for the BKM verification benches. It compares N_CH result channels against testbench-expected values every valid sample and produces exact per-channel signed deltas with warning/error tolerance flags. It also keeps correctly initialised running min/max deltas, saturating sample and error counters, and first-error capture. A run-control FSM can halt on the first error. It sits beside the per-step checkers in bkm_step/bkm_top benches and replaces ad-hoc min/max tracking.

## Interface
- W, 64: width of each compared value (two's complement).
- N_CH, 2: number of compared channels (≥1).
- LOG2CH, 1: width of channel index, ≥ ceil(log2(N_CH)), minimum 1.
- CW, 16: width of sample and error counters.

- clk  in  1  clock, all logic on rising edge.
- arst_n  in  1  asynchronous reset, active-low.
- srst  in  1  synchronous reset, active-high, overrides all other inputs except arst_n.
- enable  in  1  global clock enable; when low all state, including the FSM, holds.
- start  in  1  start/restart a run (clears statistics).
- stop  in  1  end run, return to IDLE.
- stop_on_err  in  1  mode: halt run on first error sample.
- valid  in  1  sample strobe.
- tb_val  in  N_CH*W  expected values, channel c at [c*W +: W].
- res_val  in  N_CH*W  DUT results, same packing.
- war_tol  in  W  unsigned warning tolerance.
- err_tol  in  W  unsigned error tolerance.
- delta  out  N_CH*(W+1)  last registered delta res−tb per channel.
- war, err  out  N_CH each  per-sample flags for the last registered sample.
- err_sticky  out  N_CH  channel has erred in this run.
- min_delta, max_delta  out  N_CH*(W+1) each  running signed extremes.
- n_samples  out  CW  accepted samples this run.
- n_err  out  N_CH*CW  error samples per channel.
- first_err_valid  out  1  a first error has been captured.
- first_err_ch  out  LOG2CH  channel index of the first error.
- first_err_idx  out  CW  sample index of the first error.
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 HALT.

## Operation
- Reset (arst_n low, or srst high at an edge): every output and all internal state are 0, and state = IDLE.
- FSM, evaluated only when enable=1:
  - IDLE: start → RUN.
  - RUN: stop → IDLE. Otherwise, an accepted sample with any err bit and stop_on_err=1 → HALT.
  - HALT: start → RUN. stop → IDLE.
  - start and stop together: stop wins.
  - Entering RUN via start clears delta, war, err, err_sticky, min/max, counters and first_err_* on that edge. A sample presented on the start edge is not accepted.
- Acceptance: a sample is accepted when enable=1, valid=1, state=RUN and neither start nor stop is asserted. Samples in IDLE or HALT are ignored and outputs hold.
- Arithmetic per channel:
  - delta = sext(res) − sext(tb), computed at W+1 bits; exact, no wrap.
  - |delta| is W+1 bits unsigned.
  - war = |delta| > war_tol and err = |delta| > err_tol. The two flags are independent; zero-extend the tolerances for the compare.
- Min/max:
  - On the first accepted sample of a run (n_samples==0), load both min and max with delta.
  - Afterwards, min/max update on strict signed less-than / greater-than.
- Counters:
  - n_samples increments per accepted sample.
  - n_err[c] increments when err[c]=1.
  - Both saturate at 2^CW−1; saturation does not affect other updates.
- err_sticky[c] sets on err[c] and clears only on start or reset.
- First error:
  - Captured on the first accepted sample with any err bit while first_err_valid=0.
  - first_err_ch = lowest erroring channel index.
  - first_err_idx = value of n_samples before that sample's increment, i.e. 0-based.
- srst asserted mid-run returns to IDLE with cleared statistics on that edge.

## Timing
- Latency is 1 cycle. A sample accepted at edge k updates delta, war, err, statistics and counters, visible after edge k.
- The HALT transition happens on the same edge k that registers the erroring sample. Samples at k+1 onward are ignored.
- war and err reflect the last accepted sample and hold while no sample is accepted.
- arst_n acts immediately, with no clock required. Deassertion is synchronised externally by the bench.

## Test plan
- Reset: assert arst_n=0 with random inputs → all outputs 0, state=00. Then srst=1 during RUN with stats nonzero → the next edge gives state=00 and all stats 0.
- Min/max init (W=8, N_CH=2):
  - start, then ch0 res=10/tb=7 → delta=+3, min=max=+3.
  - Next, res=5/tb=7 → delta=−2, min=−2, max=+3, n_samples=2.
- Tolerances: war_tol=2, err_tol=5.
  - Delta +3 → war=1, err=0, n_err[0]=0.
  - Delta −6 → war=1, err=1, n_err[0]=1, err_sticky[0]=1.
  - Delta +1 → war=0, err=0, sticky stays 1.
- Halt: stop_on_err=1; samples 0–3 clean, sample 4 errs on ch0 and ch1 together.
  - Result: first_err_ch=0, first_err_idx=4, state=10, n_samples=5.
  - Further valid samples leave outputs unchanged.
  - start → state=01, all stats cleared.
- Extremes (W=8):
  - res=127, tb=−128 → delta=+255 (9'h0FF).
  - res=−128, tb=127 → delta=−255 (9'h101).
  - No wrap in either case, and min/max correct.
- Saturation and controls (CW=8):
  - 300 accepted samples with err every sample → n_samples=255, n_err=255.
  - start+stop together in RUN → IDLE.
  - enable=0 with valid=1 → no change.

Source files
------------

// File: rtl/bkm_delta_stats_checker.sv
// Multi-channel result checker: exact signed deltas, tolerance flags,
// running min/max, saturating counters, first-error capture and run control.
module bkm_delta_stats_checker #(
    parameter int unsigned W      = 64,
    parameter int unsigned N_CH   = 2,
    parameter int unsigned LOG2CH = 1,
    parameter int unsigned CW     = 16
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   srst,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   stop_on_err,
    input  logic                   valid,
    input  logic [N_CH*W-1:0]      tb_val,
    input  logic [N_CH*W-1:0]      res_val,
    input  logic [W-1:0]           war_tol,
    input  logic [W-1:0]           err_tol,
    output logic [N_CH*(W+1)-1:0]  delta,
    output logic [N_CH-1:0]        war,
    output logic [N_CH-1:0]        err,
    output logic [N_CH-1:0]        err_sticky,
    output logic [N_CH*(W+1)-1:0]  min_delta,
    output logic [N_CH*(W+1)-1:0]  max_delta,
    output logic [CW-1:0]          n_samples,
    output logic [N_CH*CW-1:0]     n_err,
    output logic                   first_err_valid,
    output logic [LOG2CH-1:0]      first_err_ch,
    output logic [CW-1:0]          first_err_idx,
    output logic [1:0]             state
);

    localparam int unsigned DW = W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t            state_q;
    logic [DW-1:0]     dc      [N_CH];
    logic [DW-1:0]     mag     [N_CH];
    logic [N_CH-1:0]   war_c;
    logic [N_CH-1:0]   err_c;
    logic [LOG2CH-1:0] first_ch_c;
    logic              err_any;
    logic              accept;
    logic              clr;

    assign state   = state_q;
    assign err_any = |err_c;
    assign accept  = enable && valid && (state_q == RUN) && !start && !stop;
    // Statistics clear on sync reset or on a start that is not overridden by stop
    assign clr     = srst || (enable && start && !stop);

    // Per-channel exact delta, magnitude, tolerance flags and lowest erroring channel
    always_comb begin
        war_c      = '0;
        err_c      = '0;
        first_ch_c = '0;
        for (int c = 0; c < N_CH; c++) begin
            dc[c]    = {res_val[c*W+W-1], res_val[c*W +: W]}
                     - {tb_val[c*W+W-1], tb_val[c*W +: W]};
            mag[c]   = dc[c][W] ? (DW'(0) - dc[c]) : dc[c];
            war_c[c] = mag[c] > {1'b0, war_tol};
            err_c[c] = mag[c] > {1'b0, err_tol};
        end
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (err_c[c]) first_ch_c = LOG2CH'(c);
        end
    end

    // Run-control FSM; stop has priority over start
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else if (srst) begin
            state_q <= IDLE;
        end else if (enable) begin
            case (state_q)
                IDLE: if (start && !stop) state_q <= RUN;
                RUN: begin
                    if (stop)                                  state_q <= IDLE;
                    else if (accept && err_any && stop_on_err) state_q <= HALT;
                end
                HALT: begin
                    if (stop)       state_q <= IDLE;
                    else if (start) state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sample registers and run statistics
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            delta           <= '0;
            war             <= '0;
            err             <= '0;
            err_sticky      <= '0;
            min_delta       <= '0;
            max_delta       <= '0;
            n_samples       <= '0;
            n_err           <= '0;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_idx   <= '0;
        end else if (clr) begin
            delta           <= '0;
            war             <= '0;
            err             <= '0;
            err_sticky      <= '0;
            min_delta       <= '0;
            max_delta       <= '0;
            n_samples       <= '0;
            n_err           <= '0;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_idx   <= '0;
        end else if (accept) begin
            war <= war_c;
            err <= err_c;
            for (int c = 0; c < N_CH; c++) begin
                delta[c*DW +: DW] <= dc[c];
                if (n_samples == '0) begin
                    min_delta[c*DW +: DW] <= dc[c];
                    max_delta[c*DW +: DW] <= dc[c];
                end else begin
                    if ($signed(dc[c]) < $signed(min_delta[c*DW +: DW]))
                        min_delta[c*DW +: DW] <= dc[c];
                    if ($signed(dc[c]) > $signed(max_delta[c*DW +: DW]))
                        max_delta[c*DW +: DW] <= dc[c];
                end
                if (err_c[c]) begin
                    err_sticky[c] <= 1'b1;
                    if (n_err[c*CW +: CW] != '1)
                        n_err[c*CW +: CW] <= n_err[c*CW +: CW] + CW'(1);
                end
            end
            if (n_samples != '1) n_samples <= n_samples + CW'(1);
            if (err_any && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_ch    <= first_ch_c;
                first_err_idx   <= n_samples;
            end
        end
    end

endmodule

// File: tb/tb_bkm_delta_stats_checker.sv
// Directed bench for bkm_delta_stats_checker at W=8, N_CH=2, CW=8.
module tb_bkm_delta_stats_checker;

    localparam int unsigned W      = 8;
    localparam int unsigned N_CH   = 2;
    localparam int unsigned LOG2CH = 1;
    localparam int unsigned CW     = 8;
    localparam int unsigned DW     = W + 1;

    logic                  clk = 1'b0;
    logic                  arst_n;
    logic                  srst;
    logic                  enable;
    logic                  start;
    logic                  stop;
    logic                  stop_on_err;
    logic                  valid;
    logic [N_CH*W-1:0]     tb_val;
    logic [N_CH*W-1:0]     res_val;
    logic [W-1:0]          war_tol;
    logic [W-1:0]          err_tol;
    logic [N_CH*DW-1:0]    delta;
    logic [N_CH-1:0]       war;
    logic [N_CH-1:0]       err;
    logic [N_CH-1:0]       err_sticky;
    logic [N_CH*DW-1:0]    min_delta;
    logic [N_CH*DW-1:0]    max_delta;
    logic [CW-1:0]         n_samples;
    logic [N_CH*CW-1:0]    n_err;
    logic                  first_err_valid;
    logic [LOG2CH-1:0]     first_err_ch;
    logic [CW-1:0]         first_err_idx;
    logic [1:0]            state;

    int checks = 0;
    int errors = 0;

    bkm_delta_stats_checker #(
        .W(W), .N_CH(N_CH), .LOG2CH(LOG2CH), .CW(CW)
    ) dut (
        .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
        .start(start), .stop(stop), .stop_on_err(stop_on_err), .valid(valid),
        .tb_val(tb_val), .res_val(res_val), .war_tol(war_tol), .err_tol(err_tol),
        .delta(delta), .war(war), .err(err), .err_sticky(err_sticky),
        .min_delta(min_delta), .max_delta(max_delta), .n_samples(n_samples),
        .n_err(n_err), .first_err_valid(first_err_valid),
        .first_err_ch(first_err_ch), .first_err_idx(first_err_idx), .state(state)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] d_of(input int c);
        return 64'(delta[c*DW +: DW]);
    endfunction
    function automatic logic [63:0] mn_of(input int c);
        return 64'(min_delta[c*DW +: DW]);
    endfunction
    function automatic logic [63:0] mx_of(input int c);
        return 64'(max_delta[c*DW +: DW]);
    endfunction
    function automatic logic [63:0] ne_of(input int c);
        return 64'(n_err[c*CW +: CW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample on both channels
    task automatic put(input logic [7:0] r0, input logic [7:0] t0,
                       input logic [7:0] r1, input logic [7:0] t1);
        res_val = {r1, r0};
        tb_val  = {t1, t0};
        valid   = 1'b1;
    endtask

    task automatic do_start();
        valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        arst_n      = 1'b0;
        srst        = 1'b0;
        enable      = 1'b1;
        start       = 1'b1;
        stop        = 1'b0;
        stop_on_err = 1'b0;
        valid       = 1'b1;
        tb_val      = 16'($urandom);
        res_val     = 16'($urandom);
        war_tol     = 8'($urandom);
        err_tol     = 8'($urandom);
        #3;
        check("arst_state", 64'(state), 64'd0);
        check("arst_outs", 64'(|{delta, war, err, err_sticky, min_delta, max_delta,
                                 n_samples, n_err, first_err_valid, first_err_ch,
                                 first_err_idx}), 64'd0);
        tick();
        check("arst_hold_state", 64'(state), 64'd0);
        start   = 1'b0;
        valid   = 1'b0;
        tb_val  = '0;
        res_val = '0;
        war_tol = 8'd2;
        err_tol = 8'd5;
        #2;
        arst_n = 1'b1;
        tick();

        // Min/max initialisation and tolerances
        put(8'd10, 8'd7, 8'd0, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", 64'(state), 64'd1);
        check("start_edge_not_accepted", 64'(n_samples), 64'd0);
        tick();
        check("s1_delta0", d_of(0), 64'h003);
        check("s1_min0", mn_of(0), 64'h003);
        check("s1_max0", mx_of(0), 64'h003);
        check("s1_war", 64'(war), 64'b01);
        check("s1_err", 64'(err), 64'b00);
        check("s1_nerr0", ne_of(0), 64'd0);
        put(8'd5, 8'd7, 8'd0, 8'd0);
        tick();
        check("s2_delta0", d_of(0), 64'h1FE);
        check("s2_min0", mn_of(0), 64'h1FE);
        check("s2_max0", mx_of(0), 64'h003);
        check("s2_nsamp", 64'(n_samples), 64'd2);
        put(8'd1, 8'd7, 8'd0, 8'd0);
        tick();
        check("s3_delta0", d_of(0), 64'h1FA);
        check("s3_war", 64'(war), 64'b01);
        check("s3_err", 64'(err), 64'b01);
        check("s3_nerr0", ne_of(0), 64'd1);
        check("s3_sticky", 64'(err_sticky), 64'b01);
        check("s3_min0", mn_of(0), 64'h1FA);
        put(8'd8, 8'd7, 8'd0, 8'd0);
        tick();
        check("s4_war", 64'(war), 64'b00);
        check("s4_err", 64'(err), 64'b00);
        check("s4_sticky", 64'(err_sticky), 64'b01);
        check("s4_fe_valid", 64'(first_err_valid), 64'd1);
        check("s4_fe_idx", 64'(first_err_idx), 64'd2);
        valid = 1'b0;
        tick();
        check("novalid_delta0", d_of(0), 64'h001);
        check("novalid_nsamp", 64'(n_samples), 64'd4);
        enable = 1'b0;
        put(8'd11, 8'd7, 8'd0, 8'd0);
        tick();
        check("disable_delta0", d_of(0), 64'h001);
        check("disable_nsamp", 64'(n_samples), 64'd4);
        enable = 1'b1;
        valid  = 1'b0;

        // Synchronous reset mid-run
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("srst_state", 64'(state), 64'd0);
        check("srst_stats", 64'(|{delta, war, err, err_sticky, min_delta, max_delta,
                                  n_samples, n_err, first_err_valid, first_err_idx}), 64'd0);

        // Halt on first error
        do_start();
        stop_on_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(8'(i), 8'(i), 8'(i + 2), 8'(i));
            tick();
        end
        check("halt_pre_state", 64'(state), 64'd1);
        put(8'd16, 8'd10, 8'd0, 8'd7);
        tick();
        check("halt_fe_ch", 64'(first_err_ch), 64'd0);
        check("halt_fe_idx", 64'(first_err_idx), 64'd4);
        check("halt_state", 64'(state), 64'd2);
        check("halt_nsamp", 64'(n_samples), 64'd5);
        check("halt_err", 64'(err), 64'b11);
        check("halt_delta1", d_of(1), 64'h1F9);
        put(8'd50, 8'd0, 8'd50, 8'd0);
        tick();
        check("halted_nsamp", 64'(n_samples), 64'd5);
        check("halted_delta0", d_of(0), 64'h006);
        start = 1'b1;
        tick();
        start = 1'b0;
        stop_on_err = 1'b0;
        check("restart_state", 64'(state), 64'd1);
        check("restart_stats", 64'(|{delta, err_sticky, n_samples, n_err,
                                     first_err_valid, first_err_idx}), 64'd0);

        // Extremes without wrap
        put(8'd127, 8'h80, 8'h80, 8'd127);
        tick();
        check("ext_delta0", d_of(0), 64'h0FF);
        check("ext_delta1", d_of(1), 64'h101);
        check("ext_min1", mn_of(1), 64'h101);
        check("ext_max0", mx_of(0), 64'h0FF);
        put(8'h80, 8'd127, 8'd127, 8'h80);
        tick();
        check("ext2_min0", mn_of(0), 64'h101);
        check("ext2_max0", mx_of(0), 64'h0FF);
        check("ext2_max1", mx_of(1), 64'h0FF);
        check("ext2_err", 64'(err), 64'b11);

        // Counter saturation
        do_start();
        for (int i = 0; i < 300; i++) begin
            put(8'd20, 8'd14, 8'd3, 8'd3);
            tick();
        end
        check("sat_nsamp", 64'(n_samples), 64'd255);
        check("sat_nerr0", ne_of(0), 64'd255);
        check("sat_nerr1", ne_of(1), 64'd0);
        check("sat_delta0", d_of(0), 64'h006);

        // Control corner cases
        valid = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_state", 64'(state), 64'd0);
        check("startstop_nsamp", 64'(n_samples), 64'd255);
        put(8'd0, 8'd100, 8'd0, 8'd0);
        tick();
        check("idle_ignore_delta0", d_of(0), 64'h006);
        enable = 1'b0;
        valid  = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("disable_start_state", 64'(state), 64'd0);
        enable = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
